// File: rtl/spi_memory_burst_if.sv
// SPI pin bundle between the board-side master and the memory slave.
// Latency: none, wires only.
// Backpressure: none, the master paces every transfer through sclk/cs.
interface spi_memory_burst_if;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin;
    logic       miso_en;
    logic [3:0] leds;

    modport slave (
        input  sclk_pin, cs_pin, mosi_pin,
        output miso_pin, miso_en, leds
    );

    modport master (
        output sclk_pin, cs_pin, mosi_pin,
        input  miso_pin, miso_en, leds
    );
endinterface

// File: rtl/spi_memory_burst.sv
// SPI-slave word RAM, oversampled pins, MSB-first; multi-word bursts when SPI_MEM_BURST_EN is defined.
// Latency: SYNC_STAGES+1 clk from pin edge to state update; a write commits one clk after its last bit.
// Backpressure: none, the SPI master paces all transfers and a frame ends only on cs rising.
module spi_memory_burst #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_memory_burst_if.slave spi
);
    localparam int SH_W  = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CW    = $clog2(SH_W + 1);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Synchroniser chains; the extra top flop of sclk/cs holds the previous sample for edge detect.
    logic [SYNC_STAGES:0]   sclk_s;
    logic [SYNC_STAGES:0]   cs_s;
    logic [SYNC_STAGES-1:0] mosi_s;
    // Marks when the chains hold only post-reset pin samples; edges before that are artefacts.
    logic [SYNC_STAGES:0]   flush;

    logic sync_ok, sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

    state_t                 state, state_nxt;
    logic [CW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [SH_W-2:0]        shreg, shreg_nxt;
    logic [SH_W-1:0]        shift_cat;
    logic [ADDR_WIDTH-1:0]  addr, addr_nxt, addr_inc;
    logic [DATA_WIDTH-1:0]  out_sh, out_sh_nxt;
    logic                   miso_q, miso_nxt;
    logic                   wr_en, wr_en_nxt;
    logic [ADDR_WIDTH-1:0]  wr_addr, wr_addr_nxt;
    logic [DATA_WIDTH-1:0]  wr_dat, wr_dat_nxt;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    assign sync_ok   = flush[SYNC_STAGES];
    assign sclk_rise = sync_ok &  sclk_s[SYNC_STAGES-1] & ~sclk_s[SYNC_STAGES];
    assign sclk_fall = sync_ok & ~sclk_s[SYNC_STAGES-1] &  sclk_s[SYNC_STAGES];
    assign cs_rise   = sync_ok &  cs_s[SYNC_STAGES-1]   & ~cs_s[SYNC_STAGES];
    assign cs_fall   = sync_ok & ~cs_s[SYNC_STAGES-1]   &  cs_s[SYNC_STAGES];
    assign mosi_bit  = mosi_s[SYNC_STAGES-1];

    assign shift_cat = {shreg, mosi_bit};
    assign addr_inc  = addr + ADDR_WIDTH'(1);

    assign spi.miso_pin = miso_q;
    assign spi.miso_en  = (state == READ);
    assign spi.leds     = {1'b0, state};

    // Pin synchronisers; cs idles high so its chain resets to ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s <= '0;
            cs_s   <= '1;
            mosi_s <= '0;
            flush  <= '0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-1:0], spi.sclk_pin};
            cs_s   <= {cs_s[SYNC_STAGES-1:0], spi.cs_pin};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi.mosi_pin};
            flush  <= {flush[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Protocol state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            addr    <= '0;
            out_sh  <= '0;
            miso_q  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_dat  <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            addr    <= addr_nxt;
            out_sh  <= out_sh_nxt;
            miso_q  <= miso_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_dat  <= wr_dat_nxt;
        end
    end

    // Word RAM: contents survive reset, written one clk after the final data bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Next-state and datapath decode; cs rising overrides any same-cycle sclk action.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        addr_nxt    = addr;
        out_sh_nxt  = out_sh;
        miso_nxt    = miso_q;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_dat_nxt  = wr_dat;

        if (cs_rise) begin
            state_nxt = IDLE;
            miso_nxt  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    miso_nxt = 1'b0;
                    if (cs_fall) begin
                        state_nxt   = CMD;
                        bit_cnt_nxt = '0;
                        shreg_nxt   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shreg_nxt   = shift_cat[SH_W-2:0];
                        bit_cnt_nxt = bit_cnt + CW'(1);
                        if (bit_cnt == CW'(ADDR_WIDTH)) begin
                            addr_nxt    = shift_cat[ADDR_WIDTH:1];
                            bit_cnt_nxt = '0;
                            if (mosi_bit) begin
                                state_nxt  = READ;
                                out_sh_nxt = mem[shift_cat[ADDR_WIDTH:1]];
                            end else begin
                                state_nxt = WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (sclk_fall) begin
                        miso_nxt   = out_sh[DATA_WIDTH-1];
                        out_sh_nxt = {out_sh[DATA_WIDTH-2:0], 1'b0};
                    end else if (sclk_rise) begin
                        bit_cnt_nxt = bit_cnt + CW'(1);
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            bit_cnt_nxt = '0;
                            addr_nxt    = addr_inc;
`ifdef SPI_MEM_BURST_EN
                            out_sh_nxt  = mem[addr_inc];
`else
                            state_nxt   = DONE;
                            miso_nxt    = 1'b0;
`endif
                        end
                    end
                end
                WRITE: begin
                    if (sclk_rise) begin
                        shreg_nxt   = shift_cat[SH_W-2:0];
                        bit_cnt_nxt = bit_cnt + CW'(1);
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            bit_cnt_nxt = '0;
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = addr;
                            wr_dat_nxt  = shift_cat[DATA_WIDTH-1:0];
                            addr_nxt    = addr_inc;
`ifndef SPI_MEM_BURST_EN
                            state_nxt   = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    miso_nxt = 1'b0;
                end
                default: begin
                    state_nxt = IDLE;
                    miso_nxt  = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/spi_memory_burst.md
# spi_memory_burst

Parametrised SPI-slave memory: an external SPI master addresses an on-chip word-wide RAM through oversampled `sclk_pin`/`cs_pin`/`mosi_pin`, reading and writing words MSB-first. It is the successor to the fixed 7-bit-address, 8-bit-data SPI memory and adds generic address/data widths, a synchronous reset, an explicit MISO output-enable and optional burst transfers with address auto-increment. It sits between the board SPI pins and the lab's debug/LED logic, clocked entirely by the FPGA clock.

## Interface
- `ADDR_WIDTH`, 7, address bits; depth is 2**ADDR_WIDTH words
- `DATA_WIDTH`, 8, bits per memory word and per SPI data word
- `SYNC_STAGES`, 2, flip-flop synchroniser depth on each SPI input (≥2)

- `clk`  in  1  FPGA clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `sclk_pin`  in  1  SPI clock from master, asynchronous to `clk`
- `cs_pin`  in  1  SPI chip select, active low
- `mosi_pin`  in  1  master out, slave in
- `miso_pin`  out  1  slave out, master in
- `miso_en`  out  1  high while the block owns MISO (read data phase)
- `leds`  out  4  current FSM state encoding, for board debug

## Operation
- Each SPI input passes through `SYNC_STAGES` flops; edges detected by comparing last two synchronised samples. All protocol action keys on detected edges only.
- Frame: `cs_pin` falling edge starts; command word = ADDR_WIDTH address bits MSB-first then 1 R/W bit (1 = read, 0 = write); then data words of DATA_WIDTH bits MSB-first.
- MOSI sampled on detected `sclk_pin` rising edge; `miso_pin` updated on detected falling edge.
- States (`leds` encoding): IDLE 0, CMD 1, READ 2, WRITE 3, DONE 4.
- IDLE → CMD on cs falling edge; bit counter cleared.
- CMD: shift in ADDR_WIDTH+1 bits. On last rising edge: latch address; read → load mem[addr] into output shift register, go READ; write → WRITE.
- READ: `miso_en`=1; each falling edge presents next bit (first falling edge after command presents word MSB). After DATA_WIDTH bits shifted out, word complete.
- WRITE: shift in DATA_WIDTH bits; on last rising edge mem[addr] ← word (committed next `clk` edge).
- After each complete word: address ← (address+1) mod 2**ADDR_WIDTH; with burst (see Configuration) stay in READ (reload from new address at the completing rising edge) or WRITE; without burst go DONE.
- DONE: ignore sclk/mosi, `miso_en`=0, `miso_pin`=0; wait for cs rising edge.
- cs rising edge in any state → IDLE; partially shifted write word discarded, no memory write.
- RAM contents unaffected by `reset`; undefined after power-up.

## Timing
- Reset values: state IDLE, `leds`=0, `miso_pin`=0, `miso_en`=0, counters/shift registers/address 0, synchroniser flops 0 for sclk/mosi and 1 for cs.
- Input-to-action latency: SYNC_STAGES+1 `clk` cycles from pin transition to state update.
- Master must hold each `sclk_pin` level and each MOSI bit stable ≥ SYNC_STAGES+2 `clk` cycles; cs setup before first sclk rise ≥ same.
- MISO valid SYNC_STAGES+2 cycles after the sclk falling pin edge; master samples on following rising edge.
- Address wrap: burst at address 2**ADDR_WIDTH−1 continues at 0.
- cs rising and sclk edge detected same cycle: cs wins, no bit/write action.
- `reset` mid-frame: immediate IDLE, pending write dropped; frame only restarts on a fresh cs falling edge (cs held low across reset release is ignored until it rises and falls).

## Configuration
- `SPI_MEM_BURST_EN` defined: multi-word bursts with auto-increment as above; frame lasts until cs rises.
- Undefined: exactly one data word per frame, then DONE; address register still increments but is unused.

## Test plan
- Reset: assert `reset` 3 cycles with pins toggling → `miso_pin`=0, `miso_en`=0, `leds`=0.
- Single write/read (defaults): write 0xA5 to addr 0x15, new frame read addr 0x15 → MISO returns 10100101, `miso_en` high only during 8 data bits.
- Burst write addr 0x7F data 0x11,0x22 then burst read addr 0x7F two words → 0x11,0x22 (wrap to 0x00); without `SPI_MEM_BURST_EN` second word ignored, addr 0x00 unchanged.
- Abort: write to addr 0x03 (old 0x3C), raise cs after 5 data bits → read addr 0x03 returns 0x3C.
- Reset mid-write: `reset` after 7 of 8 data bits, keep cs low, continue clocking → memory unchanged, state IDLE until cs high→low.
- Parametrised: ADDR_WIDTH=4, DATA_WIDTH=16: write 0xBEEF to addr 0xF, read back → 0xBEEF MSB-first.
